// File: rtl/instr_ctrl_decoder_pkg.sv
// Shared definitions for the instruction control sequencer: op classes, condition
// codes, writeback/PC select encodings and sequencer states.
package instr_ctrl_decoder_pkg;

  localparam int INSTR_W = 16;

  // Op classes, shared with the opcode encoder
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_ADDU  = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_CMP   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_MOV   = 4'd8;
  localparam logic [3:0] OP_LSH   = 4'd9;
  localparam logic [3:0] OP_LOAD  = 4'd10;
  localparam logic [3:0] OP_STOR  = 4'd11;
  localparam logic [3:0] OP_BCOND = 4'd12;
  localparam logic [3:0] OP_JCOND = 4'd13;
  localparam logic [3:0] OP_JAL   = 4'd14;
  localparam logic [3:0] OP_NOP   = 4'd15;

  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_HI = 4'd4;
  localparam logic [3:0] CC_LS = 4'd5;
  localparam logic [3:0] CC_GT = 4'd6;
  localparam logic [3:0] CC_LE = 4'd7;
  localparam logic [3:0] CC_FS = 4'd8;
  localparam logic [3:0] CC_FC = 4'd9;
  localparam logic [3:0] CC_LO = 4'd10;
  localparam logic [3:0] CC_HS = 4'd11;
  localparam logic [3:0] CC_LT = 4'd12;
  localparam logic [3:0] CC_GE = 4'd13;
  localparam logic [3:0] CC_UC = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_REL = 2'd1;
  localparam logic [1:0] PC_REG = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_t;

  // opext value that selects the register (non-immediate) form of a class
  function automatic logic [3:0] reg_opext(input logic [3:0] cls);
    logic [3:0] ext;
    case (cls)
      OP_ADD:  ext = 4'b0101;
      OP_MUL:  ext = 4'b1110;
      OP_SUB:  ext = 4'b1001;
      OP_CMP:  ext = 4'b1011;
      OP_AND:  ext = 4'b0001;
      OP_OR:   ext = 4'b0010;
      OP_XOR:  ext = 4'b0011;
      OP_MOV:  ext = 4'b1101;
      default: ext = 4'b0000;
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/instr_ctrl_decoder_if.sv
// Fetch and memory handshake bundle between the control sequencer and its environment.
interface instr_ctrl_decoder_if;
  import instr_ctrl_decoder_pkg::*;

  logic [INSTR_W-1:0] instr;
  logic [3:0]         encoded;
  logic               instr_valid;
  logic               instr_ready;
  logic               mem_req;
  logic               mem_we;
  logic               mem_ready;

  modport master (
    input  instr, encoded, instr_valid, mem_ready,
    output instr_ready, mem_req, mem_we
  );

  modport slave (
    output instr, encoded, instr_valid, mem_ready,
    input  instr_ready, mem_req, mem_we
  );
endinterface

// File: rtl/instr_ctrl_decoder_cond_eval.sv
// Branch/jump condition evaluation from the 4-bit condition field and {N,L,F,Z,C} flags.
module cond_eval
  import instr_ctrl_decoder_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);

  logic n, l, f, z, c;
  assign {n, l, f, z, c} = flags;

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_EQ: taken = z;
      CC_NE: taken = !z;
      CC_CS: taken = c;
      CC_CC: taken = !c;
      CC_HI: taken = l;
      CC_LS: taken = !l;
      CC_GT: taken = n;
      CC_LE: taken = !n;
      CC_FS: taken = f;
      CC_FC: taken = !f;
      CC_LO: taken = !l && !z;
      CC_HS: taken = l || z;
      CC_LT: taken = !n && !z;
      CC_GE: taken = n || z;
      CC_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_ctrl_decoder.sv
// Multi-cycle control sequencer: latches an instruction at fetch and steps it through
// decode, execute, optional memory access and writeback, driving datapath controls.
module instr_ctrl_decoder
  import instr_ctrl_decoder_pkg::*;
#(
  parameter int DW  = 16,
  parameter int RAW = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_ctrl_decoder_if.master  bus,
  input  logic [4:0]            flags,
  output logic [3:0]            alu_sel,
  output logic                  alu_src_imm,
  output logic [DW-1:0]         imm,
  output logic [RAW-1:0]        rf_ra_a,
  output logic [RAW-1:0]        rf_ra_b,
  output logic [RAW-1:0]        rf_wa,
  output logic                  rf_we,
  output logic [1:0]            wb_sel,
  output logic                  flags_we,
  output logic [1:0]            pc_sel,
  output logic                  pc_en
);

  state_t      state;
  logic [11:0] instr_q;
  logic [3:0]  enc_q;
  logic        pc_en_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic        taken;

  logic [DW-1:0] imm_d;
  logic          src_imm_d;
  logic [DW-1:0] sext8, zext8, sext5;

  // The op nibble is already summarised by the encoder's class
  logic unused_op;
  assign unused_op = ^bus.instr[15:12];

  cond_eval u_cond (
    .cond  (instr_q[11:8]),
    .flags (flags),
    .taken (taken)
  );

  assign sext8 = {{(DW-8){instr_q[7]}}, instr_q[7:0]};
  assign zext8 = {{(DW-8){1'b0}}, instr_q[7:0]};
  assign sext5 = {{(DW-5){instr_q[4]}}, instr_q[4:0]};

  always_comb begin
    imm_d     = '0;
    src_imm_d = 1'b0;
    case (enc_q)
      OP_ADD, OP_MUL, OP_SUB, OP_CMP, OP_MOV: begin
        if (instr_q[7:4] != reg_opext(enc_q)) begin
          src_imm_d = 1'b1;
          imm_d     = sext8;
        end
      end
      OP_AND, OP_OR, OP_XOR: begin
        if (instr_q[7:4] != reg_opext(enc_q)) begin
          src_imm_d = 1'b1;
          imm_d     = zext8;
        end
      end
      OP_LSH: begin
        if (instr_q[7:5] == 3'b000) begin
          src_imm_d = 1'b1;
          imm_d     = sext5;
        end
      end
      OP_BCOND: imm_d = sext8;
      default: ;
    endcase
  end

  assign bus.instr_ready = (state == ST_FETCH);
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;

  assign alu_sel = (enc_q <= OP_LSH) ? enc_q : '0;
  assign rf_ra_a = (enc_q == OP_JCOND || enc_q == OP_JAL) ? RAW'(instr_q[3:0])
                                                          : RAW'(instr_q[11:8]);
  assign rf_ra_b = RAW'(instr_q[3:0]);
  assign rf_wa   = RAW'(instr_q[11:8]);

  // A store retires in the very cycle memory completes, so its PC strobe cannot be registered
  assign pc_en = pc_en_q ||
                 (state == ST_MEM && bus.mem_ready && enc_q == OP_STOR && !reset);

  // Execute-stage controls are registered on the DECODE exit edge so they are live during EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_FETCH;
      instr_q     <= '0;
      enc_q       <= '0;
      imm         <= '0;
      alu_src_imm <= 1'b0;
      rf_we       <= 1'b0;
      flags_we    <= 1'b0;
      pc_en_q     <= 1'b0;
      wb_sel      <= WB_ALU;
      pc_sel      <= PC_INC;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      rf_we    <= 1'b0;
      flags_we <= 1'b0;
      pc_en_q  <= 1'b0;
      wb_sel   <= WB_ALU;
      pc_sel   <= PC_INC;
      case (state)
        ST_FETCH: begin
          if (bus.instr_valid) begin
            instr_q <= bus.instr[11:0];
            enc_q   <= bus.encoded;
            state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          imm         <= imm_d;
          alu_src_imm <= src_imm_d;
          state       <= ST_EXEC;
          case (enc_q)
            OP_ADD, OP_ADDU, OP_MUL, OP_SUB, OP_CMP,
            OP_AND, OP_OR, OP_XOR, OP_MOV, OP_LSH: begin
              rf_we    <= (enc_q != OP_CMP);
              flags_we <= (enc_q inside {OP_ADD, OP_ADDU, OP_SUB, OP_CMP});
              pc_en_q  <= 1'b1;
            end
            OP_BCOND: begin
              pc_sel  <= taken ? PC_REL : PC_INC;
              pc_en_q <= 1'b1;
            end
            OP_JCOND: begin
              pc_sel  <= taken ? PC_REG : PC_INC;
              pc_en_q <= 1'b1;
            end
            OP_JAL: begin
              rf_we   <= 1'b1;
              wb_sel  <= WB_PC;
              pc_sel  <= PC_REG;
              pc_en_q <= 1'b1;
            end
            OP_NOP: pc_en_q <= 1'b1;
            default: ;
          endcase
        end
        ST_EXEC: begin
          if (enc_q == OP_LOAD || enc_q == OP_STOR) begin
            state     <= ST_MEM;
            mem_req_q <= 1'b1;
            mem_we_q  <= (enc_q == OP_STOR);
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_MEM: begin
          if (bus.mem_ready) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (enc_q == OP_LOAD) begin
              state   <= ST_WB;
              rf_we   <= 1'b1;
              wb_sel  <= WB_MEM;
              pc_en_q <= 1'b1;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_WB:   state <= ST_FETCH;
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_ctrl_decoder.sv
// Scoreboard bench for instr_ctrl_decoder: expected datapath controls are queued at
// issue and compared when the PC-update strobe appears.
module tb_instr_ctrl_decoder;
  import instr_ctrl_decoder_pkg::*;

  logic        clk;
  logic        reset;
  logic [4:0]  flags;
  logic [3:0]  alu_sel;
  logic        alu_src_imm;
  logic [15:0] imm;
  logic [3:0]  rf_ra_a, rf_ra_b, rf_wa;
  logic        rf_we, flags_we, pc_en;
  logic [1:0]  wb_sel, pc_sel;

  instr_ctrl_decoder_if ifc();

  instr_ctrl_decoder #(.DW(16), .RAW(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (ifc),
    .flags       (flags),
    .alu_sel     (alu_sel),
    .alu_src_imm (alu_src_imm),
    .imm         (imm),
    .rf_ra_a     (rf_ra_a),
    .rf_ra_b     (rf_ra_b),
    .rf_wa       (rf_wa),
    .rf_we       (rf_we),
    .wb_sel      (wb_sel),
    .flags_we    (flags_we),
    .pc_sel      (pc_sel),
    .pc_en       (pc_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] imm;
    logic        src;
    logic        we;
    logic        fwe;
    logic [1:0]  wb;
    logic [1:0]  pc;
    logic [3:0]  alu;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  wa;
    logic        mr;
    logic        mw;
  } snap_t;

  typedef struct {
    snap_t s;
    int    lat;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic snap_t mk(input logic [15:0] i, input logic src, input logic we,
                               input logic fwe, input logic [1:0] wb, input logic [1:0] pc,
                               input logic [3:0] alu, input logic [3:0] ra, input logic [3:0] rb,
                               input logic [3:0] wa, input logic mr, input logic mw);
    snap_t s;
    s.imm = i; s.src = src; s.we = we; s.fwe = fwe; s.wb = wb; s.pc = pc;
    s.alu = alu; s.ra = ra; s.rb = rb; s.wa = wa; s.mr = mr; s.mw = mw;
    return s;
  endfunction

  function automatic snap_t cur();
    snap_t s;
    s.imm = imm; s.src = alu_src_imm; s.we = rf_we; s.fwe = flags_we; s.wb = wb_sel;
    s.pc = pc_sel; s.alu = alu_sel; s.ra = rf_ra_a; s.rb = rf_ra_b; s.wa = rf_wa;
    s.mr = ifc.mem_req; s.mw = ifc.mem_we;
    return s;
  endfunction

  // Even codes test a base predicate, odd codes its complement
  function automatic logic cond_model(input logic [3:0] c, input logic [4:0] f);
    logic n, l, ff, z, cy, base;
    {n, l, ff, z, cy} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = l;
      3'd3: base = n;
      3'd4: base = ff;
      3'd5: base = !l && !z;
      3'd6: base = !n && !z;
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic issue(input logic [15:0] i, input logic [3:0] e, input bit hold);
    int g;
    @(negedge clk);
    ifc.instr = i; ifc.encoded = e; ifc.instr_valid = 1'b1;
    g = 0;
    while (ifc.instr_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (g >= 20) begin
      errors++;
      $display("FAIL accept: instr_ready=%b after %0d cycles, required 1", ifc.instr_ready, g);
    end
    @(posedge clk);
    #1;
    ifc.instr = 16'hFFFF; ifc.encoded = 4'hF; ifc.instr_valid = hold;
  endtask

  task automatic wait_pc(output int lat, output snap_t s);
    lat = -1;
    s = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (pc_en === 1'b1) begin
        lat = k;
        s = cur();
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flags = '0; ifc.mem_ready = 1'b0;
    ifc.instr_valid = 1'b0; ifc.instr = '0; ifc.encoded = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: instr_ready=%b, required 1", ifc.instr_ready);
    end
    checks++;
    if (cur() !== snap_t'('0) || pc_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %h pc_en=%b, required 0", cur(), pc_en);
    end
  endtask

  task automatic test_addi();
    exp_t e; snap_t got; int lat;
    flags = '0;
    exp_q.push_back('{mk(16'hFFFE, 1, 1, 1, WB_ALU, PC_INC, 4'd0, 4'd3, 4'hE, 4'd3, 0, 0), 2});
    issue(16'h53FE, OP_ADD, 0);
    wait_pc(lat, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e.s || lat != e.lat) begin
      errors++;
      $display("FAIL addi: got %h lat %0d, required %h lat %0d", got, lat, e.s, e.lat);
    end
    @(negedge clk);
    checks++;
    if ({pc_en, rf_we, flags_we} !== 3'b000) begin
      errors++;
      $display("FAIL addi_pulse: pc_en/rf_we/flags_we=%b, required 000", {pc_en, rf_we, flags_we});
    end
  endtask

  task automatic test_alu_forms();
    logic [15:0] ins [4];
    logic [3:0]  enc [4];
    exp_t e; snap_t got; int lat;
    ins[0] = 16'h01B2; enc[0] = OP_CMP;
    ins[1] = 16'h2180; enc[1] = OP_AND;
    ins[2] = 16'h421E; enc[2] = OP_LSH;
    ins[3] = 16'h2345; enc[3] = OP_LSH;
    exp_q.push_back('{mk(16'h0000, 0, 0, 1, WB_ALU, PC_INC, 4'd4, 4'd1, 4'd2, 4'd1, 0, 0), 2});
    exp_q.push_back('{mk(16'h0080, 1, 1, 0, WB_ALU, PC_INC, 4'd5, 4'd1, 4'd0, 4'd1, 0, 0), 2});
    exp_q.push_back('{mk(16'hFFFE, 1, 1, 0, WB_ALU, PC_INC, 4'd9, 4'd2, 4'hE, 4'd2, 0, 0), 2});
    exp_q.push_back('{mk(16'h0000, 0, 1, 0, WB_ALU, PC_INC, 4'd9, 4'd3, 4'd5, 4'd3, 0, 0), 2});
    for (int i = 0; i < 4; i++) begin
      issue(ins[i], enc[i], 0);
      wait_pc(lat, got);
      e = exp_q.pop_front();
      checks++;
      if (got !== e.s || lat != e.lat) begin
        errors++;
        $display("FAIL alu_form[%0d]: got %h lat %0d, required %h lat %0d", i, got, lat, e.s, e.lat);
      end
    end
  endtask

  task automatic test_branch();
    exp_t e; snap_t got; int lat;
    logic [4:0]  fl [3];
    logic [15:0] ins [3];
    fl[0] = 5'b00010; ins[0] = 16'hC0FD;
    fl[1] = 5'b11101; ins[1] = 16'hC0FD;
    fl[2] = 5'b11111; ins[2] = 16'hCFFD;
    exp_q.push_back('{mk(16'hFFFD, 0, 0, 0, WB_ALU, PC_REL, 4'd0, 4'd0, 4'hD, 4'd0, 0, 0), 2});
    exp_q.push_back('{mk(16'hFFFD, 0, 0, 0, WB_ALU, PC_INC, 4'd0, 4'd0, 4'hD, 4'd0, 0, 0), 2});
    exp_q.push_back('{mk(16'hFFFD, 0, 0, 0, WB_ALU, PC_INC, 4'd0, 4'hF, 4'hD, 4'hF, 0, 0), 2});
    for (int i = 0; i < 3; i++) begin
      flags = fl[i];
      issue(ins[i], OP_BCOND, 0);
      wait_pc(lat, got);
      e = exp_q.pop_front();
      checks++;
      if (got !== e.s || lat != e.lat) begin
        errors++;
        $display("FAIL bcond[%0d]: got %h lat %0d, required %h lat %0d", i, got, lat, e.s, e.lat);
      end
    end
  endtask

  task automatic test_cond_sweep();
    exp_t e; snap_t got; int lat;
    logic [7:0]  d;
    logic [15:0] ins;
    logic [3:0]  c;
    for (int unsigned k = 0; k < 32; k++) begin
      c = 4'(k >> 1);
      flags = 5'($urandom);
      d = 8'($urandom);
      ins = {4'hC, c, d};
      exp_q.push_back('{mk({{8{d[7]}}, d}, 0, 0, 0, WB_ALU,
                           cond_model(c, flags) ? PC_REL : PC_INC,
                           4'd0, c, d[3:0], c, 0, 0), 2});
      issue(ins, OP_BCOND, 0);
      wait_pc(lat, got);
      e = exp_q.pop_front();
      checks++;
      if (got !== e.s || lat != e.lat) begin
        errors++;
        $display("FAIL cond_sweep c=%0d flags=%b: got %h lat %0d, required %h lat %0d",
                 c, flags, got, lat, e.s, e.lat);
      end
    end
  endtask

  task automatic test_jumps();
    exp_t e; snap_t got; int lat;
    flags = 5'b00000;
    exp_q.push_back('{mk(16'h0000, 0, 1, 0, WB_PC, PC_REG, 4'd0, 4'd6, 4'd6, 4'hF, 0, 0), 2});
    issue(16'h4F86, OP_JAL, 0);
    wait_pc(lat, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e.s || lat != e.lat) begin
      errors++;
      $display("FAIL jal: got %h lat %0d, required %h lat %0d", got, lat, e.s, e.lat);
    end
    exp_q.push_back('{mk(16'h0000, 0, 0, 0, WB_ALU, PC_REG, 4'd0, 4'd7, 4'd7, 4'd1, 0, 0), 2});
    issue(16'hD1A7, OP_JCOND, 0);
    wait_pc(lat, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e.s || lat != e.lat) begin
      errors++;
      $display("FAIL jcond_taken: got %h lat %0d, required %h lat %0d", got, lat, e.s, e.lat);
    end
    flags = 5'b00010;
    exp_q.push_back('{mk(16'h0000, 0, 0, 0, WB_ALU, PC_INC, 4'd0, 4'd7, 4'd7, 4'd1, 0, 0), 2});
    issue(16'hD1A7, OP_JCOND, 0);
    wait_pc(lat, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e.s || lat != e.lat) begin
      errors++;
      $display("FAIL jcond_not_taken: got %h lat %0d, required %h lat %0d", got, lat, e.s, e.lat);
    end
  endtask

  task automatic test_load();
    exp_t e; snap_t got; int lat, req, k;
    bit bad_ready, we_seen;
    ifc.mem_ready = 1'b0;
    exp_q.push_back('{mk(16'h0000, 0, 1, 0, WB_MEM, PC_INC, 4'd0, 4'd4, 4'd5, 4'd4, 0, 0), 7});
    issue(16'h4405, OP_LOAD, 0);
    req = 0; lat = -1; bad_ready = 0; we_seen = 0; got = '0;
    for (k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (ifc.instr_ready !== 1'b0) bad_ready = 1;
      if (ifc.mem_req === 1'b1) begin
        req++;
        if (ifc.mem_we !== 1'b0) we_seen = 1;
        ifc.mem_ready = (req == 4);
      end else begin
        ifc.mem_ready = 1'b0;
      end
      if (pc_en === 1'b1) begin
        lat = k;
        got = cur();
        break;
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (got !== e.s || lat != e.lat) begin
      errors++;
      $display("FAIL load_wb: got %h lat %0d, required %h lat %0d", got, lat, e.s, e.lat);
    end
    checks++;
    if (req != 4) begin
      errors++;
      $display("FAIL load_req_cycles: mem_req held %0d cycles, required 4", req);
    end
    checks++;
    if (we_seen || bad_ready) begin
      errors++;
      $display("FAIL load_side: mem_we_seen=%0d ready_seen=%0d, required 0 0", we_seen, bad_ready);
    end
  endtask

  task automatic test_stor_zero_wait();
    exp_t e; snap_t got; int lat;
    ifc.mem_ready = 1'b1;
    exp_q.push_back('{mk(16'h0000, 0, 0, 0, WB_ALU, PC_INC, 4'd0, 4'd2, 4'd7, 4'd2, 1, 1), 3});
    issue(16'h4207, OP_STOR, 0);
    wait_pc(lat, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e.s || lat != e.lat) begin
      errors++;
      $display("FAIL stor: got %h lat %0d, required %h lat %0d", got, lat, e.s, e.lat);
    end
    @(negedge clk);
    ifc.mem_ready = 1'b0;
    checks++;
    if ({ifc.mem_req, pc_en, ifc.instr_ready} !== 3'b001) begin
      errors++;
      $display("FAIL stor_after: mem_req/pc_en/ready=%b, required 001",
               {ifc.mem_req, pc_en, ifc.instr_ready});
    end
  endtask

  task automatic test_reset_mem();
    int k;
    ifc.mem_ready = 1'b0;
    issue(16'h4207, OP_STOR, 0);
    for (k = 0; k < 10 && ifc.mem_req !== 1'b1; k++) @(negedge clk);
    checks++;
    if (ifc.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_mem_entry: mem_req=%b, required 1", ifc.mem_req);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ifc.mem_req, pc_en, rf_we} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mem_drop: mem_req/pc_en/rf_we=%b, required 000",
               {ifc.mem_req, pc_en, rf_we});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.instr_ready !== 1'b1 || pc_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_mem_release: ready=%b pc_en=%b, required 1 0", ifc.instr_ready, pc_en);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ins [5];
    logic [3:0]  enc [5];
    exp_t e; snap_t got; int lat;
    flags = '0;
    ins[0] = 16'h0152; enc[0] = OP_ADD;
    ins[1] = 16'h0163; enc[1] = OP_ADDU;
    ins[2] = 16'h5A80; enc[2] = OP_MOV;
    ins[3] = 16'h03E4; enc[3] = OP_MUL;
    ins[4] = 16'hF000; enc[4] = OP_NOP;
    exp_q.push_back('{mk(16'h0000, 0, 1, 1, WB_ALU, PC_INC, 4'd0, 4'd1, 4'd2, 4'd1, 0, 0), 2});
    exp_q.push_back('{mk(16'h0000, 0, 1, 1, WB_ALU, PC_INC, 4'd1, 4'd1, 4'd3, 4'd1, 0, 0), 2});
    exp_q.push_back('{mk(16'hFF80, 1, 1, 0, WB_ALU, PC_INC, 4'd8, 4'hA, 4'd0, 4'hA, 0, 0), 2});
    exp_q.push_back('{mk(16'h0000, 0, 1, 0, WB_ALU, PC_INC, 4'd2, 4'd3, 4'd4, 4'd3, 0, 0), 2});
    exp_q.push_back('{mk(16'h0000, 0, 0, 0, WB_ALU, PC_INC, 4'd0, 4'd0, 4'd0, 4'd0, 0, 0), 2});
    for (int i = 0; i < 5; i++) begin
      issue(ins[i], enc[i], 1);
      wait_pc(lat, got);
      e = exp_q.pop_front();
      checks++;
      if (got !== e.s || lat != e.lat) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h lat %0d, required %h lat %0d",
                 i, got, lat, e.s, e.lat);
      end
    end
    ifc.instr_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_alu_forms();
    test_branch();
    test_cond_sweep();
    test_jumps();
    test_load();
    test_stor_zero_wait();
    test_reset_mem();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
